// File: rtl/dfdd_fp16_pkg.sv
// Shared fp16 constants, unpacked operand view and pipeline sideband types
// for the depth divider.
package dfdd_fp16_pkg;

  localparam int          FP16_BIAS         = 15;
  localparam logic [14:0] FP16_MAX_MAG      = 15'h7BFF;
  localparam int          DEPTH_DIV_LATENCY = 14;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [10:0] mant;
    logic        is_zero;
    logic        is_special;
  } fp16_unpacked_t;

  typedef enum logic [1:0] {
    RES_DIV  = 2'd0,
    RES_ZERO = 2'd1,
    RES_SAT  = 2'd2
  } res_kind_e;

  // Everything that rides alongside the mantissa division; exp is the
  // biased, unnormalized result exponent held as a 7-bit two's complement value.
  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic        conf;
    logic        sign;
    logic [6:0]  exp;
    res_kind_e   kind;
  } side_t;

  function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x);
    fp16_unpacked_t u;
    u.sign       = x[15];
    u.exp        = x[14:10];
    u.mant       = {1'b1, x[9:0]};
    u.is_zero    = (x[14:10] == 5'd0);
    u.is_special = (x[14:10] == 5'h1F);
    return u;
  endfunction

endpackage

// File: rtl/fp16_div_step.sv
// One restoring-division step: produces one quotient bit and the shifted
// partial remainder for the next step.
module fp16_div_step #(
  parameter int DIV_W = 11
) (
  input  logic [DIV_W:0]   rem_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [DIV_W:0]   rem_o,
  output logic             q_o
);

  logic [DIV_W:0] rem_keep;

  always_comb begin
    q_o      = (rem_i >= {1'b0, div_i});
    rem_keep = q_o ? (rem_i - {1'b0, div_i}) : rem_i;
    // The kept remainder is always below the divisor, so the shift cannot overflow.
    rem_o    = rem_keep << 1;
  end

endmodule

// File: rtl/dfdd_depth_divider_fp16.sv
// Fully pipelined fp16 divider depth = v / w with confidence gating on |w|;
// one pixel per cycle, 14-cycle fixed latency, col/row tags carried along.
module dfdd_depth_divider_fp16
  import dfdd_fp16_pkg::*;
#(
  parameter logic [15:0] W_MIN        = 16'h0400,
  localparam int         EXP_WIDTH    = 5,
  localparam int         FRAC_WIDTH   = 10,
  localparam int         FP_WIDTH_REG = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] v_i,
  input  logic [FP_WIDTH_REG-1:0] w_i,
  input  logic [FP_WIDTH_REG-1:0] col_i,
  input  logic [FP_WIDTH_REG-1:0] row_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] depth_o,
  output logic                    conf_o,
  output logic [FP_WIDTH_REG-1:0] col_o,
  output logic [FP_WIDTH_REG-1:0] row_o,
  output logic                    valid_o
);

  localparam int N_STEPS = DEPTH_DIV_LATENCY - 2;
  localparam int DIV_W   = FRAC_WIDTH + 1;
  localparam int REM_W   = FRAC_WIDTH + 2;

  fp16_unpacked_t v_u, w_u;
  side_t          side_next;
  logic           conf_next;

  logic [N_STEPS:0] valid_reg;
  side_t            side_reg [0:N_STEPS];
  logic [REM_W-1:0] rem_reg  [0:N_STEPS];
  logic [DIV_W-1:0] div_reg  [0:N_STEPS];
  logic [REM_W-1:0] quo_reg  [0:N_STEPS];
  logic [REM_W-1:0] rem_step [1:N_STEPS];
  logic [N_STEPS:1] q_step;

  always_comb begin
    v_u       = fp16_unpack(v_i);
    w_u       = fp16_unpack(w_i);
    conf_next = (w_i[14:0] >= W_MIN[14:0]) && !w_u.is_special;

    side_next.col  = col_i;
    side_next.row  = row_i;
    side_next.conf = conf_next;
    side_next.sign = v_u.sign ^ w_u.sign;
    side_next.exp  = {2'b00, v_u.exp} - {2'b00, w_u.exp} + 7'(FP16_BIAS);
    side_next.kind = RES_DIV;
    // Unconfident pixels must read as a plain +0, so the sign is dropped too.
    if (!conf_next) begin
      side_next.kind = RES_ZERO;
      side_next.sign = 1'b0;
    end else if (v_u.is_zero) begin
      side_next.kind = RES_ZERO;
    end else if (v_u.is_special || w_u.is_zero) begin
      side_next.kind = RES_SAT;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= N_STEPS; gi++) begin : g_step
      fp16_div_step #(
        .DIV_W (DIV_W)
      ) u_step (
        .rem_i (rem_reg[gi-1]),
        .div_i (div_reg[gi-1]),
        .rem_o (rem_step[gi]),
        .q_o   (q_step[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[N_STEPS-1:0], valid_i};
    end
    side_reg[0] <= side_next;
    rem_reg[0]  <= {1'b0, v_u.mant};
    div_reg[0]  <= w_u.mant;
    quo_reg[0]  <= '0;
    for (int i = 1; i <= N_STEPS; i++) begin
      side_reg[i] <= side_reg[i-1];
      rem_reg[i]  <= rem_step[i];
      div_reg[i]  <= div_reg[i-1];
      quo_reg[i]  <= {quo_reg[i-1][REM_W-2:0], q_step[i]};
    end
  end

  side_t                  s_last;
  logic [REM_W-1:0]       q_last;
  logic signed [6:0]      e_adj;
  logic [FRAC_WIDTH-1:0]  frac;
  logic [FP_WIDTH_REG-1:0] depth_next;

  always_comb begin
    s_last     = side_reg[N_STEPS];
    q_last     = quo_reg[N_STEPS];
    // q[11] clear means the quotient is below 1.0: take one more bit, drop exponent.
    e_adj      = q_last[REM_W-1] ? $signed(s_last.exp) : $signed(s_last.exp) - 7'sd1;
    frac       = q_last[REM_W-1] ? q_last[REM_W-2:1] : q_last[REM_W-3:0];
    depth_next = {s_last.sign, 15'h0000};
    case (s_last.kind)
      RES_SAT: depth_next = {s_last.sign, FP16_MAX_MAG};
      RES_DIV: begin
        if (e_adj >= 7'sd31) begin
          depth_next = {s_last.sign, FP16_MAX_MAG};
        end else if (e_adj > 7'sd0) begin
          depth_next = {s_last.sign, e_adj[EXP_WIDTH-1:0], frac};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      depth_o <= '0;
      conf_o  <= 1'b0;
      col_o   <= '0;
      row_o   <= '0;
    end else begin
      valid_o <= valid_reg[N_STEPS];
      if (valid_reg[N_STEPS]) begin
        depth_o <= depth_next;
        conf_o  <= s_last.conf;
        col_o   <= s_last.col;
        row_o   <= s_last.row;
      end
    end
  end

endmodule

// File: tb/tb_dfdd_depth_divider_fp16.sv
// Self-checking bench for dfdd_depth_divider_fp16: directed spec vectors,
// randomized frames against an arithmetic reference, and reset flushing.
module tb_dfdd_depth_divider_fp16;

  localparam logic [15:0] W_MIN = 16'h0400;
  localparam int          LAT   = 14;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] v_i, w_i, col_i, row_i;
  logic        valid_i;
  logic [15:0] depth_o, col_o, row_o;
  logic        conf_o, valid_o;

  always #5 clk_i = ~clk_i;

  dfdd_depth_divider_fp16 #(
    .W_MIN (W_MIN)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .v_i     (v_i),
    .w_i     (w_i),
    .col_i   (col_i),
    .row_i   (row_i),
    .valid_i (valid_i),
    .depth_o (depth_o),
    .conf_o  (conf_o),
    .col_o   (col_o),
    .row_o   (row_o),
    .valid_o (valid_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        hist_valid [32];
  logic [15:0] hist_v [32], hist_w [32], hist_col [32], hist_row [32];

  logic        obs_valid, obs_conf;
  logic [15:0] obs_depth, obs_col, obs_row;
  logic        exp_valid, exp_conf;
  logic [15:0] exp_depth, exp_col, exp_row;

  typedef struct {
    logic        vld;
    logic [15:0] v, w, c, r;
  } stim_t;

  // Reference: exact integer mantissa quotient, normalized and truncated.
  function automatic logic [16:0] model(input logic [15:0] v, input logic [15:0] w);
    int ev, ew, mv, mw, q, e, fr;
    logic s;
    logic [15:0] wmin;
    wmin = W_MIN;
    ev = int'(v[14:10]);
    ew = int'(w[14:10]);
    if (!((w[14:0] >= wmin[14:0]) && (ew != 31))) return 17'h0;
    s = v[15] ^ w[15];
    if (ev == 0) return {1'b1, s, 15'h0000};
    if (ev == 31 || ew == 0) return {1'b1, s, 15'h7BFF};
    mv = 1024 + int'(v[9:0]);
    mw = 1024 + int'(w[9:0]);
    q  = (mv * 2048) / mw;
    e  = ev - ew + 15;
    if (q < 2048) begin
      q = q * 2;
      e = e - 1;
    end
    if (e <= 0) return {1'b1, s, 15'h0000};
    if (e >= 31) return {1'b1, s, 15'h7BFF};
    fr = (q - 2048) / 2;
    return {1'b1, s, 5'(e), 10'(fr)};
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(99) < 75) x[14:10] = 5'($urandom_range(25, 5));
    return x;
  endfunction

  // One clock: sample outputs, derive what should be there from the pixel
  // driven LAT cycles ago, then drive this cycle's inputs.
  task automatic step(input logic rst, input logic vld, input logic [15:0] v, input logic [15:0] w,
                      input logic [15:0] c, input logic [15:0] r);
    int k, s;
    logic [16:0] m;
    @(negedge clk_i);
    obs_valid = valid_o;
    obs_conf  = conf_o;
    obs_depth = depth_o;
    obs_col   = col_o;
    obs_row   = row_o;
    k = (cyc + 32 - LAT) % 32;
    exp_valid = hist_valid[k];
    m = model(hist_v[k], hist_w[k]);
    exp_conf  = m[16];
    exp_depth = m[15:0];
    exp_col   = hist_col[k];
    exp_row   = hist_row[k];
    if (rst) for (int i = 0; i < 32; i++) hist_valid[i] = 1'b0;
    s = cyc % 32;
    hist_valid[s] = vld && !rst;
    hist_v[s]   = v;
    hist_w[s]   = w;
    hist_col[s] = c;
    hist_row[s] = r;
    rst_i   = rst;
    valid_i = vld;
    v_i     = v;
    w_i     = w;
    col_i   = c;
    row_i   = r;
    cyc++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    n_tests++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", obs_valid); end
    n_tests++;
    if (obs_depth !== 16'h0) begin n_fail++; $display("FAIL reset_depth got %h want 0000", obs_depth); end
    n_tests++;
    if (obs_conf !== 1'b0) begin n_fail++; $display("FAIL reset_conf got %b want 0", obs_conf); end
    n_tests++;
    if (obs_col !== 16'h0 || obs_row !== 16'h0) begin
      n_fail++; $display("FAIL reset_tags got %h/%h want 0000/0000", obs_col, obs_row);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_tests++;
      if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid cycle %0d got %b want 0", i, obs_valid); end
    end
    $display("[TB] reset: outputs idle after reset");
  endtask

  task automatic test_directed();
    logic [15:0] tv [12] = '{16'h3C00, 16'h4200, 16'h3C00, 16'hBC00, 16'h7800, 16'h0400,
                             16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'hFC00};
    logic [15:0] tw [12] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 16'h2000, 16'h7800,
                             16'h0000, 16'h0200, 16'h7C00, 16'h0400, 16'h03FF, 16'h3C00};
    logic [15:0] td [12] = '{16'h3C00, 16'h3E00, 16'h3555, 16'hBC00, 16'h7BFF, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h7400, 16'h0000, 16'hFBFF};
    logic        tc [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int j = 0;
    for (int i = 0; i < 12 + LAT + 2; i++) begin
      if (i < 12) step(1'b0, 1'b1, tv[i], tw[i], 16'(5 + i), 16'(7 + i));
      else        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_tests++;
      if (obs_valid !== exp_valid) begin
        n_fail++; $display("FAIL dir_valid cycle %0d got %b want %b", i, obs_valid, exp_valid);
      end
      if (exp_valid && j < 12) begin
        n_tests++;
        if (obs_depth !== td[j] || obs_conf !== tc[j]) begin
          n_fail++;
          $display("FAIL dir_depth vec %0d v=%h w=%h got %h/%b want %h/%b",
                   j, tv[j], tw[j], obs_depth, obs_conf, td[j], tc[j]);
        end
        n_tests++;
        if (obs_col !== 16'(5 + j) || obs_row !== 16'(7 + j)) begin
          n_fail++; $display("FAIL dir_tags vec %0d got %h/%h want %h/%h", j, obs_col, obs_row, 16'(5 + j), 16'(7 + j));
        end
        $display("[TB] directed v=%h w=%h -> depth=%h conf=%b", tv[j], tw[j], obs_depth, obs_conf);
        j++;
      end
    end
    n_tests++;
    if (j != 12) begin n_fail++; $display("FAIL dir_count got %0d want 12", j); end
  endtask

  task automatic test_frame(input int width, input int height, input int gap_pct);
    stim_t q[$];
    stim_t st;
    int n_in = 0, n_out = 0, errs = 0;
    for (int r = 0; r < height; r++) begin
      for (int c = 0; c < width; c++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          st = '{1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
          q.push_back(st);
        end
        st = '{1'b1, rand_fp16(), rand_fp16(), 16'(c), 16'(r)};
        q.push_back(st);
        n_in++;
      end
    end
    for (int i = 0; i < LAT + 2; i++) begin
      st = '{1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
      q.push_back(st);
    end
    foreach (q[i]) begin
      step(1'b0, q[i].vld, q[i].v, q[i].w, q[i].c, q[i].r);
      n_tests++;
      if (obs_valid !== exp_valid) begin
        n_fail++; errs++; $display("FAIL frame_valid step %0d got %b want %b", i, obs_valid, exp_valid);
      end
      if (exp_valid) begin
        n_out++;
        n_tests++;
        if (obs_depth !== exp_depth || obs_conf !== exp_conf) begin
          n_fail++; errs++;
          $display("FAIL frame_depth col=%0d row=%0d got %h/%b want %h/%b",
                   exp_col, exp_row, obs_depth, obs_conf, exp_depth, exp_conf);
        end
        n_tests++;
        if (obs_col !== exp_col || obs_row !== exp_row) begin
          n_fail++; errs++; $display("FAIL frame_tags got %h/%h want %h/%h", obs_col, obs_row, exp_col, exp_row);
        end
      end
    end
    n_tests++;
    if (n_out != n_in) begin n_fail++; $display("FAIL frame_count got %0d want %0d", n_out, n_in); end
    $display("[TB] frame %0dx%0d gaps=%0d%%: %0d pixels, %0d errors", width, height, gap_pct, n_in, errs);
  endtask

  task automatic test_reset_flush();
    int n_out = 0, seen_at = -1;
    logic [15:0] seen_col = 16'h0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rand_fp16(), 16'h3C00, 16'(100 + i), 16'h1);
    step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int s = 0; s <= LAT + 6; s++) begin
      if (s == 0) step(1'b0, 1'b1, 16'h4200, 16'h4000, 16'hBEEF, 16'h0042);
      else        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_tests++;
      if (obs_valid !== exp_valid) begin
        n_fail++; $display("FAIL flush_valid step %0d got %b want %b", s, obs_valid, exp_valid);
      end
      if (obs_valid === 1'b1) begin
        n_out++;
        seen_at  = s;
        seen_col = obs_col;
      end
    end
    n_tests++;
    if (n_out != 1) begin n_fail++; $display("FAIL flush_count got %0d want 1", n_out); end
    n_tests++;
    if (seen_at != LAT || seen_col !== 16'hBEEF) begin
      n_fail++; $display("FAIL flush_latency got step %0d col %h want step %0d col beef", seen_at, seen_col, LAT);
    end
    $display("[TB] reset flush: %0d outputs after reset, first at +%0d", n_out, seen_at);
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    v_i     = 16'h0;
    w_i     = 16'h0;
    col_i   = 16'h0;
    row_i   = 16'h0;
    for (int i = 0; i < 32; i++) begin
      hist_valid[i] = 1'b0;
      hist_v[i]     = 16'h0;
      hist_w[i]     = 16'h0;
      hist_col[i]   = 16'h0;
      hist_row[i]   = 16'h0;
    end
    test_reset();
    test_directed();
    test_frame(40, 30, 0);
    test_frame(40, 30, 30);
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
